collision_ctrl: RTL and testbench
=================================

COLLISION_CTRL -- requirements
Module: collision_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, meaning: score that ends the game.
REQ-002 Parameter COOL_TICKS, default 8, meaning: number of enable ticks during which a repeat collision pulse on the same axis is suppressed.
REQ-003 Parameter PAD_H, default 80, meaning: paddle height in pixels.
REQ-004 Port clk, input, 1, meaning: single system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1, meaning: synchronous, active-high reset.
REQ-006 Port enable, input, 1, meaning: ball-move tick; detection and cooldown counting happen only on enable=1 cycles.
REQ-007 Port xCoord, input, 10, meaning: ball x position, 0..639.
REQ-008 Port yCoord, input, 9, meaning: ball y position, 0..479.
REQ-009 Port padL, input, 9, meaning: top y of the left paddle.
REQ-010 Port padR, input, 9, meaning: top y of the right paddle.
REQ-011 Port vCol, output, 1, meaning: one-clock pulse requesting a vertical direction flip.
REQ-012 Port hCol, output, 1, meaning: one-clock pulse requesting a horizontal direction flip.
REQ-013 Port point, output, 1, meaning: one-clock pulse when a point is scored.
REQ-014 Port scoreL, output, 4, meaning: left player score.
REQ-015 Port scoreR, output, 4, meaning: right player score.
REQ-016 Port gameOver, output, 1, meaning: level, high once either score reaches WIN_SCORE.

Function
REQ-017 Wall hit SHALL be detected when yCoord <= 10 or yCoord >= 469, with enable=1, state PLAY, and v-cooldown at 0.
REQ-018 Left paddle hit SHALL be detected when 30 <= xCoord <= 40 and padL <= yCoord < padL+PAD_H, using 10-bit compare with no wrap; the right paddle hit SHALL be detected when 600 <= xCoord <= 610 and padR <= yCoord < padR+PAD_H; in both cases enable=1, state PLAY, and h-cooldown at 0 are also required.
REQ-019 vCol and hCol SHALL be registered: asserted exactly one clock, on the cycle after the detecting cycle.
REQ-020 On each pulse, the axis cooldown counter SHALL load COOL_TICKS and decrement on each enable=1 cycle down to 0; detections SHALL be ignored while it is nonzero.
REQ-021 vCol and hCol SHALL be independent, and both may pulse in the same cycle (corner hit).
REQ-022 FSM states SHALL be PLAY, SCORED, WAIT_CENTER, and OVER.
REQ-023 In PLAY with enable=1: xCoord < 30 SHALL increment scoreR and xCoord > 610 SHALL increment scoreL, each going to SCORED; miss takes priority over collision detection.
REQ-024 SCORED SHALL last one clock, assert point, and go to OVER if either score equals WIN_SCORE, else to WAIT_CENTER.
REQ-025 WAIT_CENTER SHALL remain until 30 <= xCoord <= 610, then go to PLAY and clear both cooldowns.
REQ-026 OVER SHALL hold gameOver=1, suppress vCol, hCol, and point, freeze the scores, and exit only on reset.
REQ-027 Scores SHALL never exceed WIN_SCORE; no wrap-around.

Reset
REQ-028 reset=1 SHALL set state PLAY and set vCol, hCol, point, and gameOver to 0, scoreL and scoreR to 0, and both cooldowns to 0 on the next edge.
REQ-029 reset SHALL take priority over enable and all FSM activity, including mid-cooldown and in SCORED.

Structure
REQ-030 Package pong_pkg SHALL hold the screen size (640, 480), wall bounds (10, 469), paddle x bands (30..40, 600..610), miss bounds (30, 610), and the FSM state typedef.
REQ-031 Sub-module col_pulse (detect-in, enable, cooldown counter, registered pulse-out) SHALL be instantiated twice, once for v and once for h.

Verification
REQ-032 Verify: y=10, x=320, enable held high -> vCol high exactly 1 clock later for 1 clock; no second vCol during the next 8 enable ticks.
REQ-033 Verify: x=35, y=150, padL=100 -> hCol pulse; with padL=200 -> no hCol.
REQ-034 Verify: x=29 in PLAY -> scoreR 0->1, point pulse 1 clock; no further increment while x stays <30; x=320 -> back to PLAY.
REQ-035 Verify: x=605, y=10, padR=0 -> vCol and hCol pulse in the same cycle.
REQ-036 Verify: scoreL reaches 7 -> gameOver=1, collisions are ignored, and reset clears everything to 0 in PLAY.
REQ-037 Verify: reset asserted mid-cooldown (4 ticks left) -> y=10 on the first enable after reset gives an immediate vCol.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared screen geometry, collision bands and game FSM state type for the
// pong collision/score controller.
package pong_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [8:0] Y_WALL_TOP = 9'd10;
   localparam logic [8:0] Y_WALL_BOT = 9'd469;

   localparam logic [9:0] X_PADL_MIN = 10'd30;
   localparam logic [9:0] X_PADL_MAX = 10'd40;
   localparam logic [9:0] X_PADR_MIN = 10'd600;
   localparam logic [9:0] X_PADR_MAX = 10'd610;

   localparam logic [9:0] X_MISS_L = 10'd30;
   localparam logic [9:0] X_MISS_R = 10'd610;

   typedef enum logic [1:0] {
      PLAY        = 2'd0,
      SCORED      = 2'd1,
      WAIT_CENTER = 2'd2,
      OVER        = 2'd3
   } state_t;

   function automatic logic in_band(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/col_pulse.sv
// One collision axis: qualifies a raw detect with a cooldown down-counter and
// emits a registered single-clock flip request.
module col_pulse #(
   parameter int COOL_TICKS = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_enable,
   input  logic i_detect,
   input  logic i_clear,
   output logic o_pulse
);

   localparam int CW = (COOL_TICKS < 1) ? 1 : $clog2(COOL_TICKS + 1);

   logic [CW-1:0] r_cnt;
   logic          r_pulse;
   logic          w_idle;
   logic          w_fire;

   assign w_idle = (r_cnt == '0);
   assign w_fire = i_enable && i_detect && w_idle;

   // Counter only moves on ball ticks, so the hold-off tracks ball travel, not time.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= w_fire;
         if (i_clear) begin
            r_cnt <= '0;
         end else if (w_fire) begin
            r_cnt <= CW'(COOL_TICKS);
         end else if (i_enable && !w_idle) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/collision_ctrl.sv
// Ball collision detection and score keeping for a two-player pong game.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   PLAY        | ball in play; walls/paddles detected, misses score a point
//   SCORED      | single clock; point pulse, decide game end
//   WAIT_CENTER | wait for the ball to be re-served inside the field
//   OVER        | a player reached WIN_SCORE; frozen until reset
module collision_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE  = 7,
   parameter int COOL_TICKS = 8,
   parameter int PAD_H      = 80
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [9:0] xCoord,
   input  logic [8:0] yCoord,
   input  logic [8:0] padL,
   input  logic [8:0] padR,
   output logic       vCol,
   output logic       hCol,
   output logic       point,
   output logic [3:0] scoreL,
   output logic [3:0] scoreR,
   output logic       gameOver
);

   localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_score_l;
   logic [3:0] r_score_r;
   logic [3:0] w_score_l_nxt;
   logic [3:0] w_score_r_nxt;

   logic       w_in_play;
   logic       w_miss_l;
   logic       w_miss_r;
   logic       w_wall;
   logic [9:0] w_y10;
   logic [9:0] w_padl_top;
   logic [9:0] w_padl_end;
   logic [9:0] w_padr_top;
   logic [9:0] w_padr_end;
   logic       w_hit_l;
   logic       w_hit_r;
   logic       w_det_v;
   logic       w_det_h;
   logic       w_recentred;
   logic       w_clear;
   logic       w_win;
   logic       w_vpulse;
   logic       w_hpulse;

   assign w_in_play = (r_state == PLAY);
   assign w_miss_l  = (xCoord < X_MISS_L);
   assign w_miss_r  = (xCoord > X_MISS_R);
   assign w_wall    = (yCoord <= Y_WALL_TOP) || (yCoord >= Y_WALL_BOT);

   // Paddle spans are compared in 10 bits so padX + PAD_H never wraps.
   assign w_y10      = {1'b0, yCoord};
   assign w_padl_top = {1'b0, padL};
   assign w_padl_end = w_padl_top + 10'(PAD_H);
   assign w_padr_top = {1'b0, padR};
   assign w_padr_end = w_padr_top + 10'(PAD_H);

   assign w_hit_l = in_band(xCoord, X_PADL_MIN, X_PADL_MAX) &&
                    (w_y10 >= w_padl_top) && (w_y10 < w_padl_end);
   assign w_hit_r = in_band(xCoord, X_PADR_MIN, X_PADR_MAX) &&
                    (w_y10 >= w_padr_top) && (w_y10 < w_padr_end);

   // A miss in the same tick wins over any bounce.
   assign w_det_v = w_in_play && !w_miss_l && !w_miss_r && w_wall;
   assign w_det_h = w_in_play && !w_miss_l && !w_miss_r && (w_hit_l || w_hit_r);

   assign w_recentred = in_band(xCoord, X_MISS_L, X_MISS_R);
   assign w_clear     = (r_state == WAIT_CENTER) && w_recentred;
   assign w_win       = (r_score_l == WIN4) || (r_score_r == WIN4);

   col_pulse #(.COOL_TICKS(COOL_TICKS)) u_col_v (
      .clk      (clk),
      .reset    (reset),
      .i_enable (enable),
      .i_detect (w_det_v),
      .i_clear  (w_clear),
      .o_pulse  (w_vpulse)
   );

   col_pulse #(.COOL_TICKS(COOL_TICKS)) u_col_h (
      .clk      (clk),
      .reset    (reset),
      .i_enable (enable),
      .i_detect (w_det_h),
      .i_clear  (w_clear),
      .o_pulse  (w_hpulse)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= PLAY;
         r_score_l <= 4'd0;
         r_score_r <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_score_l <= w_score_l_nxt;
         r_score_r <= w_score_r_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_score_l_nxt = r_score_l;
      w_score_r_nxt = r_score_r;
      case (r_state)
         PLAY: begin
            if (enable && w_miss_l) begin
               if (r_score_r < WIN4) w_score_r_nxt = r_score_r + 4'd1;
               w_state_nxt = SCORED;
            end else if (enable && w_miss_r) begin
               if (r_score_l < WIN4) w_score_l_nxt = r_score_l + 4'd1;
               w_state_nxt = SCORED;
            end
         end
         SCORED: begin
            w_state_nxt = w_win ? OVER : WAIT_CENTER;
         end
         WAIT_CENTER: begin
            if (w_recentred) w_state_nxt = PLAY;
         end
         OVER: begin
            w_state_nxt = OVER;
         end
         default: begin
            w_state_nxt = PLAY;
         end
      endcase
   end

   assign vCol     = w_vpulse && (r_state != OVER);
   assign hCol     = w_hpulse && (r_state != OVER);
   assign point    = (r_state == SCORED);
   assign gameOver = (r_state == OVER);
   assign scoreL   = r_score_l;
   assign scoreR   = r_score_r;

endmodule

// File: tb/tb_collision_ctrl.sv
// Bench for collision_ctrl: directed game scenarios followed by random play,
// all checked against a rule-level model of the game.
module tb_collision_ctrl;

   localparam int WIN  = 7;
   localparam int COOL = 8;
   localparam int PADH = 80;

   localparam int P_PLAY   = 0;
   localparam int P_SCORED = 1;
   localparam int P_WAIT   = 2;
   localparam int P_OVER   = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [9:0] x;
   logic [8:0] y;
   logic [8:0] pl;
   logic [8:0] pr;
   logic       vCol;
   logic       hCol;
   logic       point;
   logic [3:0] scoreL;
   logic [3:0] scoreR;
   logic       gameOver;

   int n_cmp  = 0;
   int n_fail = 0;

   int m_phase = P_PLAY;
   int m_sl    = 0;
   int m_sr    = 0;
   int m_vcd   = 0;
   int m_hcd   = 0;
   bit m_v     = 1'b0;
   bit m_h     = 1'b0;

   int vcount;

   always #5 clk = ~clk;

   collision_ctrl #(.WIN_SCORE(WIN), .COOL_TICKS(COOL), .PAD_H(PADH)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .xCoord   (x),
      .yCoord   (y),
      .padL     (pl),
      .padR     (pr),
      .vCol     (vCol),
      .hCol     (hCol),
      .point    (point),
      .scoreL   (scoreL),
      .scoreR   (scoreR),
      .gameOver (gameOver)
   );

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Game rules applied once per clock edge with the inputs present at that edge.
   task automatic model_edge();
      int  xi, yi, pli, pri;
      bit  miss, wall, pad, hit_v, hit_h, clr;
      xi  = int'(x);
      yi  = int'(y);
      pli = int'(pl);
      pri = int'(pr);
      if (reset) begin
         m_phase = P_PLAY;
         m_sl = 0; m_sr = 0; m_vcd = 0; m_hcd = 0;
         m_v = 1'b0; m_h = 1'b0;
         return;
      end
      miss  = (xi < 30) || (xi > 610);
      wall  = (yi <= 10) || (yi >= 469);
      pad   = ((xi >= 30) && (xi <= 40) && (yi >= pli) && (yi < pli + PADH)) ||
              ((xi >= 600) && (xi <= 610) && (yi >= pri) && (yi < pri + PADH));
      hit_v = enable && (m_phase == P_PLAY) && !miss && wall && (m_vcd == 0);
      hit_h = enable && (m_phase == P_PLAY) && !miss && pad && (m_hcd == 0);
      clr   = (m_phase == P_WAIT) && (xi >= 30) && (xi <= 610);
      m_v = hit_v;
      m_h = hit_h;
      if (clr) m_vcd = 0;
      else if (hit_v) m_vcd = COOL;
      else if (enable && m_vcd > 0) m_vcd--;
      if (clr) m_hcd = 0;
      else if (hit_h) m_hcd = COOL;
      else if (enable && m_hcd > 0) m_hcd--;
      case (m_phase)
         P_PLAY: begin
            if (enable && xi < 30) begin
               if (m_sr < WIN) m_sr++;
               m_phase = P_SCORED;
            end else if (enable && xi > 610) begin
               if (m_sl < WIN) m_sl++;
               m_phase = P_SCORED;
            end
         end
         P_SCORED: m_phase = (m_sl == WIN || m_sr == WIN) ? P_OVER : P_WAIT;
         P_WAIT:   if (clr) m_phase = P_PLAY;
         default:  m_phase = P_OVER;
      endcase
   endtask

   task automatic step(input bit r, input bit e, input int xi, input int yi,
                       input int pli, input int pri);
      logic [3:0] e_sl, e_sr;
      reset  = r;
      enable = e;
      x      = 10'(xi);
      y      = 9'(yi);
      pl     = 9'(pli);
      pr     = 9'(pri);
      @(posedge clk);
      model_edge();
      #1;
      e_sl = 4'(m_sl);
      e_sr = 4'(m_sr);
      chk("vCol", {3'b0, vCol}, {3'b0, m_v});
      chk("hCol", {3'b0, hCol}, {3'b0, m_h});
      chk("point", {3'b0, point}, {3'b0, (m_phase == P_SCORED)});
      chk("gameOver", {3'b0, gameOver}, {3'b0, (m_phase == P_OVER)});
      chk("scoreL", scoreL, e_sl);
      chk("scoreR", scoreR, e_sr);
   endtask

   initial begin
      int sel, xi, yi;
      bit r, e;

      step(1, 0, 320, 240, 0, 0);
      step(1, 1, 320, 10, 0, 0);
      chk("rst_score", {scoreL[1:0], scoreR[1:0]}, 4'd0);

      // wall hit with enable held: pulse once, then 8 quiet ticks, then again
      step(0, 1, 320, 10, 300, 300);
      chk("wall_first", {3'b0, vCol}, 4'd1);
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 320, 10, 300, 300);
         vcount += int'(vCol);
      end
      chk("wall_cooldown", 4'(vcount), 4'd0);
      step(0, 1, 320, 10, 300, 300);
      chk("wall_rearm", {3'b0, vCol}, 4'd1);

      // left paddle hit and miss-by-position
      step(0, 1, 35, 150, 100, 300);
      chk("padL_hit", {3'b0, hCol}, 4'd1);
      for (int i = 0; i < 9; i++) step(0, 1, 320, 240, 100, 300);
      step(0, 1, 35, 150, 200, 300);
      chk("padL_off", {3'b0, hCol}, 4'd0);

      // corner: wall and right paddle in the same tick
      for (int i = 0; i < 10; i++) step(0, 1, 320, 240, 200, 0);
      step(0, 1, 605, 10, 200, 0);
      chk("corner", {2'b0, vCol, hCol}, 4'b0011);

      // left miss scores for the right player exactly once
      step(0, 1, 29, 240, 200, 0);
      chk("miss_scoreR", scoreR, 4'd1);
      chk("miss_point", {3'b0, point}, 4'd1);
      for (int i = 0; i < 4; i++) step(0, 1, 29, 240, 200, 0);
      chk("miss_hold", scoreR, 4'd1);
      step(0, 1, 320, 240, 200, 0);
      step(0, 1, 320, 240, 200, 0);

      // right misses until the left player wins
      for (int k = 0; k < WIN; k++) begin
         step(0, 1, 611, 240, 200, 0);
         step(0, 1, 611, 240, 200, 0);
         step(0, 1, 320, 240, 200, 0);
      end
      chk("win_over", {3'b0, gameOver}, 4'd1);
      chk("win_scoreL", scoreL, 4'd7);
      for (int i = 0; i < 4; i++) step(0, 1, 605, 10, 200, 0);
      step(0, 1, 611, 240, 200, 0);
      chk("over_freeze", scoreL, 4'd7);
      step(1, 1, 320, 240, 200, 0);
      chk("over_reset", {gameOver, point, scoreL[1:0]}, 4'd0);

      // reset in the middle of a cooldown re-arms immediately
      step(0, 1, 320, 10, 200, 200);
      for (int i = 0; i < 4; i++) step(0, 1, 320, 240, 200, 200);
      step(1, 0, 320, 240, 200, 200);
      step(0, 1, 320, 10, 200, 200);
      chk("rst_rearm", {3'b0, vCol}, 4'd1);

      // random play
      for (int i = 0; i < 4000; i++) begin
         r   = ($urandom_range(0, 299) == 0);
         e   = ($urandom_range(0, 3) != 0);
         sel = int'($urandom_range(0, 5));
         case (sel)
            0:       xi = int'($urandom_range(0, 639));
            1:       xi = int'($urandom_range(24, 46));
            2:       xi = int'($urandom_range(594, 616));
            default: xi = int'($urandom_range(100, 540));
         endcase
         if ($urandom_range(0, 2) == 0) yi = int'($urandom_range(0, 479));
         else if ($urandom_range(0, 1) == 0) yi = int'($urandom_range(0, 14));
         else yi = int'($urandom_range(465, 479));
         if ($urandom_range(0, 1) == 0) yi = int'($urandom_range(0, 479));
         step(r, e, xi, yi, int'($urandom_range(0, 400)), int'($urandom_range(0, 400)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
